// File: rtl/block_to_word_converter.sv
// Unpacks BSIZE-bit blocks into WSIZE-bit words, lowest word slot first, behind a valid/ready port.
// Optional feature macro: BTW_PREFETCH_EN adds a spare block register that hides block-fetch latency.
module block_to_word_converter #(
    parameter int WSIZE  = 32,
    parameter int BSIZE  = 256,
    parameter int RD_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BSIZE-1:0] block_in,
    input  logic             block_hold,
    output logic             read_block,
    output logic [WSIZE-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             last_word,
    output logic             busy
);
    localparam int WPERB = BSIZE / WSIZE;
    localparam int CW    = $clog2(WPERB);
    localparam logic [CW-1:0] LAST_IDX = CW'(WPERB - 1);
    localparam logic [1:0]    LAT      = 2'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [BSIZE-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             read_q, read_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       lat_cnt_q, lat_cnt_d;

    logic             capture;
    logic             transfer;
    logic             at_last;
    logic             issue;
    logic             spare_valid;
    logic             spare_take;
    logic [BSIZE-1:0] spare_data;

    // A fetch is tracked independently of the FSM so a prefetch and a demand fetch share one counter.
    assign capture  = inflight_q && !read_q && (lat_cnt_q == LAT);
    assign transfer = (state_q == SHIFT) && word_ready;
    assign at_last  = (count_q == LAST_IDX);

    assign read_block = read_q;
    assign word_out   = shift_q[WSIZE-1:0];
    assign word_valid = (state_q == SHIFT);
    assign last_word  = (state_q == SHIFT) && at_last;
    assign busy       = (state_q != IDLE);

`ifdef BTW_PREFETCH_EN
    logic [BSIZE-1:0] spare_q;
    logic             spare_valid_q;

    assign spare_valid = spare_valid_q;
    assign spare_data  = spare_q;
    assign issue       = (state_q == SHIFT) && !spare_valid_q && !block_hold && !inflight_q;
    assign spare_take  = spare_valid_q && ((state_q == IDLE) || (transfer && at_last));

    always_ff @(posedge clock) begin
        if (reset) begin
            spare_q       <= '0;
            spare_valid_q <= 1'b0;
        end else if (capture && (state_q == SHIFT) && !(transfer && at_last)) begin
            spare_q       <= block_in;
            spare_valid_q <= 1'b1;
        end else if (spare_take) begin
            spare_valid_q <= 1'b0;
        end
    end
`else
    assign spare_valid = 1'b0;
    assign spare_data  = '0;
    assign issue       = 1'b0;
    assign spare_take  = 1'b0;
`endif

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (read_q) begin
            lat_cnt_d = 2'd1;
        end else if (capture) begin
            lat_cnt_d = 2'd0;
        end else if (inflight_q) begin
            lat_cnt_d = lat_cnt_q + 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        read_d     = 1'b0;
        inflight_d = inflight_q;
        if (capture) begin
            inflight_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (spare_valid) begin
                    shift_d = spare_data;
                    count_d = '0;
                    state_d = SHIFT;
                end else if (!block_hold) begin
                    read_d     = 1'b1;
                    inflight_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (capture) begin
                    shift_d = block_in;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (issue) begin
                    read_d     = 1'b1;
                    inflight_d = 1'b1;
                end
                if (transfer) begin
                    shift_d = shift_q >> WSIZE;
                    if (at_last) begin
                        // A waiting block continues the stream with no bubble.
                        count_d = '0;
                        if (spare_valid) begin
                            shift_d = spare_data;
                        end else if (capture) begin
                            shift_d = block_in;
                        end else if (inflight_q || issue) begin
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            read_q     <= 1'b0;
            inflight_q <= 1'b0;
            lat_cnt_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            read_q     <= read_d;
            inflight_q <= inflight_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

endmodule
